// File: rtl/sram2rw_arbiter.sv
// ---------------------------------------------------------------------------
// sram2rw_arbiter
//
// Round-robin arbiter sharing one two-port (2RW) SRAM macro among NREQ
// requesters. Up to two requests are granted per cycle, one per macro port.
// A port-2 candidate that would collide with the port-1 grant (same address,
// at least one write) is skipped. Read data returns exactly one cycle after
// the grant, steered back to the requester that issued the read.
//
// Ports
//   clock, reset_n       clock; asynchronous active-low reset
//   req_valid/ready/we   per-requester handshake and direction (1 = write)
//   req_addr/req_wdata   packed per-requester address / write data
//   resp_valid/rdata     per-requester read-return strobe and packed data
//   sram_csb*/web*/oeb*  macro port controls, active-low
//   sram_a*/sram_i*      macro port address / write data
//   sram_o*              macro port read data (registered inside the macro)
// ---------------------------------------------------------------------------
module sram2rw_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          resp_valid,
  output logic [NREQ*DATA_W-1:0]   resp_rdata,
  output logic                     sram_csb1,
  output logic                     sram_csb2,
  output logic                     sram_web1,
  output logic                     sram_web2,
  output logic                     sram_oeb1,
  output logic                     sram_oeb2,
  output logic [ADDR_W-1:0]        sram_a1,
  output logic [ADDR_W-1:0]        sram_a2,
  output logic [DATA_W-1:0]        sram_i1,
  output logic [DATA_W-1:0]        sram_i2,
  input  logic [DATA_W-1:0]        sram_o1,
  input  logic [DATA_W-1:0]        sram_o2
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // (base + k) mod NREQ for base < NREQ and k < NREQ; works for any NREQ,
  // not only powers of two.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] base,
                                                input int               k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDX_W'(s);
  endfunction

  // Unpacked views of the packed request buses.
  logic [ADDR_W-1:0] addr_a  [NREQ];
  logic [DATA_W-1:0] wdata_a [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_a[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_a[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  // State
  logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic             tag1_vld_q, tag1_vld_d;
  logic             tag2_vld_q, tag2_vld_d;
  logic [IDX_W-1:0] tag1_id_q,  tag1_id_d;
  logic [IDX_W-1:0] tag2_id_q,  tag2_id_d;

  // Arbitration
  logic             g1_vld, g2_vld;
  logic [IDX_W-1:0] g1_idx, g2_idx;
  logic [IDX_W-1:0] cand;
  logic             g1_act, g2_act;
  logic             g1_we,  g2_we;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    g1_vld = 1'b0;
    g1_idx = '0;
    g2_vld = 1'b0;
    g2_idx = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_inc(rr_ptr_q, k);
      if (req_valid[cand]) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = cand;
        end else if (!g2_vld &&
                     !((addr_a[cand] == addr_a[g1_idx]) &&
                       (req_we[cand] || req_we[g1_idx]))) begin
          // A hazarding candidate is passed over and stays pending; the
          // scan keeps looking for a later, non-conflicting requester.
          g2_vld = 1'b1;
          g2_idx = cand;
        end
      end
    end
  end

  // Grants are suppressed combinationally while reset is asserted.
  assign g1_act = g1_vld & reset_n;
  assign g2_act = g2_vld & reset_n;
  assign g1_we  = req_we[g1_idx];
  assign g2_we  = req_we[g2_idx];

  always_comb begin
    req_ready = '0;
    if (g1_act) req_ready[g1_idx] = 1'b1;
    if (g2_act) req_ready[g2_idx] = 1'b1;
  end

  // Macro port drive; an idle port is fully deselected with zeroed buses.
  assign sram_csb1 = ~g1_act;
  assign sram_web1 = ~(g1_act &  g1_we);
  assign sram_oeb1 = ~(g1_act & ~g1_we);
  assign sram_a1   = g1_act ? addr_a[g1_idx] : '0;
  assign sram_i1   = (g1_act & g1_we) ? wdata_a[g1_idx] : '0;

  assign sram_csb2 = ~g2_act;
  assign sram_web2 = ~(g2_act &  g2_we);
  assign sram_oeb2 = ~(g2_act & ~g2_we);
  assign sram_a2   = g2_act ? addr_a[g2_idx] : '0;
  assign sram_i2   = (g2_act & g2_we) ? wdata_a[g2_idx] : '0;

  // Next state: pointer moves just past the last requester served this cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (g2_act)      rr_ptr_d = wrap_inc(g2_idx, 1);
    else if (g1_act) rr_ptr_d = wrap_inc(g1_idx, 1);

    tag1_vld_d = g1_act & ~g1_we;
    tag2_vld_d = g2_act & ~g2_we;
    tag1_id_d  = g1_idx;
    tag2_id_d  = g2_idx;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      tag1_vld_q <= 1'b0;
      tag2_vld_q <= 1'b0;
      tag1_id_q  <= '0;
      tag2_id_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag1_vld_q <= tag1_vld_d;
      tag2_vld_q <= tag2_vld_d;
      tag1_id_q  <= tag1_id_d;
      tag2_id_q  <= tag2_id_d;
    end
  end

  // Read return: the macro already registers its output, so data is passed
  // straight through to the tagged requester. The two tags can never name
  // the same requester because each requester wins at most one port.
  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    if (tag1_vld_q) begin
      resp_valid[tag1_id_q]                    = 1'b1;
      resp_rdata[tag1_id_q*DATA_W +: DATA_W]   = sram_o1;
    end
    if (tag2_vld_q) begin
      resp_valid[tag2_id_q]                    = 1'b1;
      resp_rdata[tag2_id_q*DATA_W +: DATA_W]   = sram_o2;
    end
  end

endmodule

// File: tb/tb_sram2rw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram2rw_arbiter
//
// Bench for sram2rw_arbiter with a behavioural 2RW macro attached. A
// reference model computes grants, macro pin values and read data from the
// arbitration rules; expected read responses go into a queue that a separate
// monitor drains whenever the DUT strobes resp_valid.
// ---------------------------------------------------------------------------
module tb_sram2rw_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 4;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid, req_ready, req_we, resp_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata, resp_rdata;
  logic                 sram_csb1, sram_csb2, sram_web1, sram_web2;
  logic                 sram_oeb1, sram_oeb2;
  logic [AW-1:0]        sram_a1, sram_a2;
  logic [DW-1:0]        sram_i1, sram_i2, sram_o1, sram_o2;

  always #5 clock = ~clock;

  sram2rw_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .sram_csb1  (sram_csb1),
    .sram_csb2  (sram_csb2),
    .sram_web1  (sram_web1),
    .sram_web2  (sram_web2),
    .sram_oeb1  (sram_oeb1),
    .sram_oeb2  (sram_oeb2),
    .sram_a1    (sram_a1),
    .sram_a2    (sram_a2),
    .sram_i1    (sram_i1),
    .sram_i2    (sram_i2),
    .sram_o1    (sram_o1),
    .sram_o2    (sram_o2)
  );

  // Behavioural 2RW macro: one-cycle registered read, write on the edge.
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clock) begin
    if (!sram_csb1 && !sram_oeb1) sram_o1 <= mem[sram_a1];
    if (!sram_csb2 && !sram_oeb2) sram_o2 <= mem[sram_a2];
    if (!sram_csb1 && !sram_web1) mem[sram_a1] <= sram_i1;
    if (!sram_csb2 && !sram_web2) mem[sram_a2] <= sram_i2;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard
  typedef struct {
    int            stamp;
    int            req;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [1<<AW];
  int            m_rr;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            resp_count [NREQ];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] exp_port(input int g, input logic [3:0] we,
                                           input logic [15:0] addr,
                                           input logic [15:0] wd);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (g < 0) return {3'b111, 4'h0, 4'h0};
    a = addr[g*AW +: AW];
    d = wd[g*DW +: DW];
    if (we[g]) return {3'b001, a, d};   // csb=0 web=0 oeb=1
    return {3'b010, a, 4'h0};           // csb=0 web=1 oeb=0
  endfunction

  function automatic logic [15:0] pack4(input logic [3:0] x0, input logic [3:0] x1,
                                        input logic [3:0] x2, input logic [3:0] x3);
    return {x3, x2, x1, x0};
  endfunction

  // Drive one cycle of requests at the negedge, model the expected grants,
  // queue expected reads, then check ready and macro pins at negedge+1.
  task automatic drive_cycle(input logic [3:0] v, input logic [3:0] we,
                             input logic [15:0] addr, input logic [15:0] wd);
    int            g1, g2, i;
    logic [3:0]    exp_rdy;
    logic [AW-1:0] ai, a1;
    exp_t          e;
    @(negedge clock);
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;

    g1 = -1;
    g2 = -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_rr + k) % NREQ;
      if (v[i]) begin
        ai = addr[i*AW +: AW];
        if (g1 < 0) g1 = i;
        else if (g2 < 0) begin
          a1 = addr[g1*AW +: AW];
          if (!(ai == a1 && (we[i] || we[g1]))) g2 = i;
        end
      end
    end
    exp_rdy = '0;
    if (g1 >= 0) exp_rdy[g1] = 1'b1;
    if (g2 >= 0) exp_rdy[g2] = 1'b1;

    // Reads see memory before this cycle's writes (hazards keep them apart).
    if (g1 >= 0 && !we[g1]) begin
      e.stamp = cyc; e.req = g1; e.data = ref_mem[addr[g1*AW +: AW]];
      exp_q.push_back(e);
    end
    if (g2 >= 0 && !we[g2]) begin
      e.stamp = cyc; e.req = g2; e.data = ref_mem[addr[g2*AW +: AW]];
      exp_q.push_back(e);
    end
    if (g1 >= 0 && we[g1]) ref_mem[addr[g1*AW +: AW]] = wd[g1*DW +: DW];
    if (g2 >= 0 && we[g2]) ref_mem[addr[g2*AW +: AW]] = wd[g2*DW +: DW];

    if (g2 >= 0)      m_rr = (g2 + 1) % NREQ;
    else if (g1 >= 0) m_rr = (g1 + 1) % NREQ;

    #1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("port1_pins", 32'({sram_csb1, sram_web1, sram_oeb1, sram_a1, sram_i1}),
          32'(exp_port(g1, we, addr, wd)));
    check("port2_pins", 32'({sram_csb2, sram_web2, sram_oeb2, sram_a2, sram_i2}),
          32'(exp_port(g2, we, addr, wd)));
  endtask

  task automatic idle_cycle();
    drive_cycle(4'h0, 4'h0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n   = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    exp_q.delete();
    m_rr      = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: pops expectations issued in the previous cycle and compares
  // them against whatever the DUT strobes now.
  initial begin
    logic [3:0]    exp_v;
    logic [DW-1:0] exp_d [NREQ];
    exp_t          e;
    forever begin
      @(negedge clock);
      #1;
      if (reset_n === 1'b1) begin
        exp_v = '0;
        for (int i = 0; i < NREQ; i++) exp_d[i] = '0;
        while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
          e = exp_q.pop_front();
          if (e.stamp == cyc - 1) begin
            exp_v[e.req] = 1'b1;
            exp_d[e.req] = e.data;
          end else begin
            check("resp_missing", 32'(e.stamp), 32'(cyc - 1));
          end
        end
        check("resp_valid", 32'(resp_valid), 32'(exp_v));
        for (int i = 0; i < NREQ; i++) begin
          if (resp_valid[i]) resp_count[i]++;
          if (exp_v[i])
            check($sformatf("resp_rdata[%0d]", i),
                  32'(resp_rdata[i*DW +: DW]), 32'(exp_d[i]));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0 [NREQ];
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) resp_count[i] = 0;
    sram_o1   = '0;
    sram_o2   = '0;
    m_rr      = 0;
    reset_n   = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Reset asserted mid-cycle with all requesters valid.
    @(negedge clock);
    req_valid = 4'hF;
    req_we    = 4'h0;
    req_addr  = pack4(4'd0, 4'd1, 4'd2, 4'd3);
    #1;
    check("pre_reset_ready", 32'(req_ready), 32'(4'b0011));
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    m_rr = 0;
    #1;
    check("reset_ready", 32'(req_ready), 32'(4'b0000));
    check("reset_csb", 32'({sram_csb1, sram_csb2}), 32'(2'b11));
    check("reset_resp_valid", 32'(resp_valid), 32'(4'b0000));
    check("reset_port1", 32'({sram_csb1, sram_web1, sram_oeb1, sram_a1, sram_i1}),
          32'(11'h700));
    check("reset_port2", 32'({sram_csb2, sram_web2, sram_oeb2, sram_a2, sram_i2}),
          32'(11'h700));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive_cycle(4'hF, 4'h0, pack4(4'd0, 4'd1, 4'd2, 4'd3), 16'h0);
    check("first_grant", 32'(req_ready), 32'(4'b0011));
    idle_cycle();

    // Dual write then dual read.
    do_reset();
    drive_cycle(4'b0011, 4'b0011, pack4(4'd3, 4'd7, 4'd0, 4'd0),
                pack4(4'hA, 4'h5, 4'h0, 4'h0));
    check("dual_write_ready", 32'(req_ready), 32'(4'b0011));
    drive_cycle(4'b1100, 4'b0000, pack4(4'd0, 4'd0, 4'd3, 4'd7), 16'h0);
    check("dual_read_ready", 32'(req_ready), 32'(4'b1100));
    idle_cycle();
    #1;
    check("dual_read_resp_valid", 32'(resp_valid), 32'(4'b1100));
    check("dual_read_slice2", 32'(resp_rdata[2*DW +: DW]), 32'(4'hA));
    check("dual_read_slice3", 32'(resp_rdata[3*DW +: DW]), 32'(4'h5));

    // Write/write hazard on the same address.
    do_reset();
    drive_cycle(4'b0011, 4'b0011, pack4(4'd9, 4'd9, 4'd0, 4'd0),
                pack4(4'h3, 4'hC, 4'h0, 4'h0));
    check("ww_hazard_ready", 32'(req_ready), 32'(4'b0001));
    check("ww_hazard_csb2", 32'(sram_csb2), 32'(1'b1));
    drive_cycle(4'b0010, 4'b0010, pack4(4'd9, 4'd9, 4'd0, 4'd0),
                pack4(4'h3, 4'hC, 4'h0, 4'h0));
    check("ww_second_ready", 32'(req_ready), 32'(4'b0010));
    drive_cycle(4'b0100, 4'b0000, pack4(4'd0, 4'd0, 4'd9, 4'd0), 16'h0);
    idle_cycle();
    #1;
    check("ww_readback", 32'(resp_rdata[2*DW +: DW]), 32'(4'hC));

    // Read/write hazard with skip to a later requester.
    do_reset();
    drive_cycle(4'b0111, 4'b0001, pack4(4'd2, 4'd2, 4'd4, 4'd0),
                pack4(4'h6, 4'h0, 4'h0, 4'h0));
    check("rw_skip_ready", 32'(req_ready), 32'(4'b0101));
    // Pointer is now 3: req3 wins port 1, req1 wins port 2.
    drive_cycle(4'b1110, 4'b0000, pack4(4'd0, 4'd2, 4'd4, 4'd5), 16'h0);
    check("rw_next_ready", 32'(req_ready), 32'(4'b1010));
    idle_cycle();

    // Round-robin fairness with continuous distinct reads.
    do_reset();
    for (int i = 0; i < NREQ; i++) cnt0[i] = resp_count[i];
    for (int c = 0; c < 8; c++) begin
      drive_cycle(4'hF, 4'h0, pack4(4'd1, 4'd2, 4'd3, 4'd4), 16'h0);
      check($sformatf("rr_ready_c%0d", c), 32'(req_ready),
            32'((c % 2 == 0) ? 4'b0011 : 4'b1100));
    end
    idle_cycle();
    #1;
    for (int i = 0; i < NREQ; i++)
      check($sformatf("rr_resp_count[%0d]", i), 32'(resp_count[i] - cnt0[i]), 32'd4);

    // Randomised traffic; narrow address range to provoke hazards.
    for (int c = 0; c < 400; c++) begin
      drive_cycle(4'($urandom), 4'($urandom),
                  pack4(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                        4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))),
                  16'($urandom));
    end
    idle_cycle();
    idle_cycle();

    // Reset while a read is in flight: its response must be dropped.
    do_reset();
    drive_cycle(4'b0010, 4'b0000, pack4(4'd0, 4'd5, 4'd0, 4'd0), 16'h0);
    check("inflight_grant", 32'(req_ready), 32'(4'b0010));
    @(posedge clock);
    #1;
    reset_n   = 1'b0;
    req_valid = '0;
    exp_q.delete();
    m_rr = 0;
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    #2;
    check("inflight_dropped", 32'(resp_valid[1]), 32'(1'b0));
    drive_cycle(4'hF, 4'h0, pack4(4'd1, 4'd2, 4'd3, 4'd4), 16'h0);
    check("post_reset_rr", 32'(req_ready), 32'(4'b0011));
    idle_cycle();
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
